// File: rtl/io_bus_arbiter.sv
// Two-requester io bus arbiter: one whole transaction per grant, m1 priority with
// bounded m0 starvation, slave ready handshake and timeout abort.
module io_bus_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int HOLD_MAX = 4,
   parameter int TIMEOUT  = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [2:0]        m0_size,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_done,
   output logic              m0_err,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [2:0]        m1_size,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_done,
   output logic              m1_err,
   output logic              s_read_en,
   output logic              s_write_en,
   output logic [2:0]        s_size,
   output logic [ADDR_W-1:0] s_address,
   output logic [DATA_W-1:0] s_write_value,
   input  logic [DATA_W-1:0] s_read_value,
   input  logic              s_ready
);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t      state, state_nxt;
   logic [3:0]  hold_cnt;
   logic [7:0]  tmo_cnt;
   logic        owner;
   logic        we_q;
   logic        grant_m0, grant_m1;
   logic        hold_full, tmo_hit, finish;

   // m0 has waited through HOLD_MAX m1 grants: m1 must yield this round
   assign hold_full = m0_req && (hold_cnt == 4'(HOLD_MAX));
   assign tmo_hit   = !s_ready && (tmo_cnt == 8'(TIMEOUT - 1));
   assign finish    = s_ready || tmo_hit;

   always_comb begin
      state_nxt = state;
      grant_m0  = 1'b0;
      grant_m1  = 1'b0;
      case (state)
         IDLE: begin
            if (m1_req && !hold_full) grant_m1 = 1'b1;
            else if (m0_req)          grant_m0 = 1'b1;
            if (grant_m0 || grant_m1) state_nxt = BUSY;
         end
         BUSY:    if (finish) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt      <= '0;
         tmo_cnt       <= '0;
         owner         <= 1'b0;
         we_q          <= 1'b0;
         m0_rdata      <= '0;
         m0_done       <= 1'b0;
         m0_err        <= 1'b0;
         m1_rdata      <= '0;
         m1_done       <= 1'b0;
         m1_err        <= 1'b0;
         s_read_en     <= 1'b0;
         s_write_en    <= 1'b0;
         s_size        <= '0;
         s_address     <= '0;
         s_write_value <= '0;
      end else begin
         m0_done <= 1'b0;
         m0_err  <= 1'b0;
         m1_done <= 1'b0;
         m1_err  <= 1'b0;
         case (state)
            IDLE: begin
               tmo_cnt <= '0;
               if (!m0_req || grant_m0)
                  hold_cnt <= '0;
               else if (grant_m1 && hold_cnt != 4'(HOLD_MAX))
                  hold_cnt <= hold_cnt + 4'd1;
               if (grant_m1) begin
                  owner         <= 1'b1;
                  we_q          <= m1_we;
                  s_read_en     <= !m1_we;
                  s_write_en    <= m1_we;
                  s_size        <= m1_size;
                  s_address     <= m1_addr;
                  s_write_value <= m1_wdata;
               end else if (grant_m0) begin
                  owner         <= 1'b0;
                  we_q          <= m0_we;
                  s_read_en     <= !m0_we;
                  s_write_en    <= m0_we;
                  s_size        <= m0_size;
                  s_address     <= m0_addr;
                  s_write_value <= m0_wdata;
               end
            end
            BUSY: begin
               if (finish) begin
                  s_read_en  <= 1'b0;
                  s_write_en <= 1'b0;
                  // ready beats a simultaneous timeout; aborts always zero rdata
                  if (owner) begin
                     m1_done <= 1'b1;
                     m1_err  <= !s_ready;
                     if (!s_ready)  m1_rdata <= '0;
                     else if (!we_q) m1_rdata <= s_read_value;
                  end else begin
                     m0_done <= 1'b1;
                     m0_err  <= !s_ready;
                     if (!s_ready)  m0_rdata <= '0;
                     else if (!we_q) m0_rdata <= s_read_value;
                  end
               end else begin
                  tmo_cnt <= tmo_cnt + 8'd1;
               end
            end
            RESP:    tmo_cnt <= '0;
            default: tmo_cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Self-checking bench for io_bus_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level arbitration/response model.
module tb_io_bus_arbiter;
   localparam int HOLD_MAX = 4;
   localparam int TIMEOUT  = 15;

   logic        clk = 1'b0, rst = 1'b1;
   logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
   logic [2:0]  m0_size = 0, m1_size = 0;
   logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
   logic [31:0] m0_rdata, m1_rdata;
   logic        m0_done, m0_err, m1_done, m1_err;
   logic        s_read_en, s_write_en;
   logic [2:0]  s_size;
   logic [31:0] s_address, s_write_value;
   logic [31:0] s_read_value = 0;
   logic        s_ready = 0;

   io_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .HOLD_MAX(HOLD_MAX), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_done(m0_done), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_done(m1_done), .m1_err(m1_err),
      .s_read_en(s_read_en), .s_write_en(s_write_en), .s_size(s_size),
      .s_address(s_address), .s_write_value(s_write_value),
      .s_read_value(s_read_value), .s_ready(s_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   int checks = 0, failures = 0;

   // transaction-level model state
   logic        p[2];
   logic        we_r[2];
   logic [2:0]  sz_r[2];
   logic [31:0] ad_r[2], wd_r[2], last[2];
   int          streak;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic drive();
      m0_req = p[0]; m0_we = we_r[0]; m0_size = sz_r[0]; m0_addr = ad_r[0]; m0_wdata = wd_r[0];
      m1_req = p[1]; m1_we = we_r[1]; m1_size = sz_r[1]; m1_addr = ad_r[1]; m1_wdata = wd_r[1];
   endtask

   task automatic new_req(input int m, input logic we, input logic [2:0] sz,
                          input logic [31:0] ad, input logic [31:0] wd);
      p[m] = 1'b1; we_r[m] = we; sz_r[m] = sz; ad_r[m] = ad; wd_r[m] = wd;
      drive();
   endtask

   task automatic rand_req(input int m);
      logic [31:0] a;
      a = $urandom;
      a[0] = (m == 1);
      new_req(m, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, {m0_rdata[15:0] | m1_rdata[15:0] | s_address[15:0] | s_write_value[15:0],
                m0_rdata[31:16] | m1_rdata[31:16] | s_address[31:16] | s_write_value[31:16]},
          32'd0);
      chk(tag, {24'd0, m0_done, m0_err, m1_done, m1_err, s_read_en, s_write_en, 2'd0} |
               {29'd0, s_size}, 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1; p[0] = 0; p[1] = 0; s_ready = 0; drive();
      repeat (2) @(negedge clk);
      chk_all_zero("reset_outputs");
      rst = 1'b0;
      streak = 0; last[0] = 0; last[1] = 0;
   endtask

   // Called at the negedge of an IDLE cycle with requests already driven.
   // Slave answers in BUSY cycle d+1; d+1 > TIMEOUT means it never answers.
   task automatic run_round(input int d, input logic [31:0] rv, input bit drop);
      int          w;
      logic        p0g, ok;
      logic [31:0] er;
      p0g = p[0];
      w = (p[1] && !(p[0] && streak == HOLD_MAX)) ? 1 : 0;
      @(negedge clk);
      for (int i = 1; i <= TIMEOUT; i++) begin
         chk1("busy_rd_en", s_read_en, !we_r[w]);
         chk1("busy_wr_en", s_write_en, we_r[w]);
         chk("busy_addr", s_address, ad_r[w]);
         if (i == 1) begin
            chk("busy_size", {29'd0, s_size}, {29'd0, sz_r[w]});
            chk("busy_wval", s_write_value, wd_r[w]);
            chk1("busy_no_done", m0_done | m1_done, 1'b0);
            if (drop) begin p[w] = 1'b0; drive(); end
         end
         if (i == d + 1) begin s_ready = 1'b1; s_read_value = rv; end
         @(negedge clk);
         s_ready = 1'b0;
         if (i == d + 1) break;
      end
      ok = (d + 1 <= TIMEOUT);
      er = !ok ? 32'd0 : (!we_r[w] ? rv : last[w]);
      last[w] = er;
      chk1("resp_done", w ? m1_done : m0_done, 1'b1);
      chk1("resp_err", w ? m1_err : m0_err, !ok);
      chk("resp_rdata", w ? m1_rdata : m0_rdata, er);
      chk1("resp_other_done", w ? m0_done : m1_done, 1'b0);
      chk("resp_other_rdata", w ? m0_rdata : m1_rdata, last[1-w]);
      chk1("resp_strobes", s_read_en | s_write_en, 1'b0);
      p[w] = 1'b0; drive();
      streak = (w == 1 && p0g) ? ((streak < HOLD_MAX) ? streak + 1 : streak) : 0;
      @(negedge clk);
      chk1("idle_done_clr", m0_done | m1_done, 1'b0);
   endtask

   initial begin
      p[0] = 0; p[1] = 0;
      for (int m = 0; m < 2; m++) begin
         we_r[m] = 0; sz_r[m] = 0; ad_r[m] = 0; wd_r[m] = 0; last[m] = 0;
      end
      streak = 0;
      @(negedge clk);
      do_reset();

      // m0 read, immediate ready
      new_req(0, 1'b0, 3'd2, 32'h100, 32'h0);
      run_round(0, 32'hCAFEF00D, 1'b0);

      // simultaneous requests: m1 first, then m0
      new_req(0, 1'b0, 3'd1, 32'h200, 32'h0);
      new_req(1, 1'b1, 3'd2, 32'h301, 32'h1234);
      run_round(1, 32'h11112222, 1'b0);
      run_round(0, 32'h33334444, 1'b0);

      // starvation bound: both requesters re-request every round
      do_reset();
      new_req(0, 1'b0, 3'd0, 32'h400, 32'h0);
      new_req(1, 1'b0, 3'd0, 32'h501, 32'h0);
      for (int r = 0; r < 10; r++) begin
         run_round(0, $urandom, 1'b0);
         if (!p[0]) new_req(0, 1'b0, 3'd0, 32'h400 + 32'(r << 4), 32'h0);
         if (!p[1]) new_req(1, 1'b0, 3'd0, 32'h501 + 32'(r << 4), 32'h0);
      end
      p[0] = 0; p[1] = 0; drive();
      @(negedge clk); streak = 0;

      // timeout on a write
      new_req(1, 1'b1, 3'd2, 32'h20, 32'h55);
      run_round(99, 32'hDEADBEEF, 1'b0);

      // async reset in the middle of an access
      new_req(0, 1'b0, 3'd2, 32'h604, 32'h0);
      @(negedge clk);
      chk1("pre_rst_rd_en", s_read_en, 1'b1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk_all_zero("async_rst");
      @(negedge clk);
      chk1("rst_no_done", m0_done | m1_done, 1'b0);
      rst = 1'b0; streak = 0; last[0] = 0; last[1] = 0;
      run_round(1, 32'h0BADF00D, 1'b0);

      // requester drops req during BUSY
      new_req(0, 1'b0, 3'd1, 32'h708, 32'h0);
      run_round(3, 32'h77778888, 1'b1);
      repeat (3) begin
         @(negedge clk);
         chk1("no_regrant", s_read_en | s_write_en, 1'b0);
         chk1("no_extra_done", m0_done, 1'b0);
      end

      // randomized traffic
      for (int r = 0; r < 60; r++) begin
         int k, d;
         for (int m = 0; m < 2; m++)
            if (!p[m] && $urandom_range(0, 1) == 1) rand_req(m);
         if (!p[0] && !p[1]) rand_req(0);
         k = $urandom_range(0, 9);
         d = (k == 9) ? 30 : (k % 4);
         run_round(d, $urandom, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
